// File: rtl/bcd_to_binary.sv
// Sequential packed-BCD to unsigned binary converter.
// Uses reverse double-dabble: each cycle shifts right one bit, then subtracts 3 from every digit that is >= 8.
module bcd_to_binary #(
  parameter int DIGITS = 7,
  parameter int BIN_W  = 24
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Do_Translate,
  input  logic [4*DIGITS-1:0]   Bcd,
  output logic [BIN_W-1:0]      Bin,
  output logic                  Done_Sig,
  output logic                  Busy,
  output logic                  Err
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int WORK_W = BCD_W + BIN_W;
  localparam int CNT_W  = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [WORK_W-1:0]   work_q, work_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                bad_q, bad_d;
  logic [BIN_W-1:0]    bin_q, bin_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;

  logic                any_bad;
  logic [WORK_W-1:0]   shifted;
  logic [WORK_W-1:0]   adjusted;
  logic [3:0]          digit;

  always_comb begin
    any_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (Bcd[4*i +: 4] > 4'd9) any_bad = 1'b1;
    end
  end

  // One reverse double-dabble step on the whole working register.
  always_comb begin
    digit    = '0;
    shifted  = work_q >> 1;
    adjusted = shifted;
    for (int i = 0; i < DIGITS; i++) begin
      digit = shifted[BIN_W + 4*i +: 4];
      if (digit >= 4'd8) adjusted[BIN_W + 4*i +: 4] = digit - 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    bad_d   = bad_q;
    bin_d   = bin_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (Do_Translate) begin
          work_d  = {Bcd, {BIN_W{1'b0}}};
          cnt_d   = '0;
          busy_d  = 1'b1;
          bad_d   = any_bad;
          state_d = any_bad ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        work_d = adjusted;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b1;
        state_d = IDLE;
        if (bad_q) begin
          bin_d = '0;
          err_d = 1'b1;
        end else begin
          bin_d = work_q[BIN_W-1:0];
          err_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      bad_q   <= 1'b0;
      bin_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      bad_q   <= bad_d;
      bin_q   <= bin_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign Bin      = bin_q;
  assign Done_Sig = done_q;
  assign Busy     = busy_q;
  assign Err      = err_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Self-checking bench for bcd_to_binary: fixed vector table, multi-cycle corner sequences,
// and a randomized sweep against a decimal reference model.
module tb_bcd_to_binary;

  localparam int DIGITS = 7;
  localparam int BIN_W  = 24;
  localparam int BCD_W  = 4 * DIGITS;

  logic             Clk = 1'b0;
  logic             Rst = 1'b1;
  logic             Do_Translate = 1'b0;
  logic [BCD_W-1:0] Bcd = '0;
  logic [BIN_W-1:0] Bin;
  logic             Done_Sig;
  logic             Busy;
  logic             Err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [BCD_W-1:0] bcd;
    logic [BIN_W-1:0] bin;
    logic             err;
    int               lat;
  } vec_t;

  vec_t vecs[9];

  bcd_to_binary #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .Do_Translate (Do_Translate),
    .Bcd          (Bcd),
    .Bin          (Bin),
    .Done_Sig     (Done_Sig),
    .Busy         (Busy),
    .Err          (Err)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Decimal interpretation of the packed digits; any digit above 9 makes the operand invalid.
  task automatic refModel(input logic [BCD_W-1:0] bcd, output logic [BIN_W-1:0] bin, output logic err);
    int unsigned val = 0;
    err = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      int unsigned d = int'(bcd[4*i +: 4]);
      if (d > 9) err = 1'b1;
      val = val * 10 + d;
    end
    bin = err ? '0 : BIN_W'(val);
  endtask

  function automatic logic [BCD_W-1:0] toBcd(input int unsigned value);
    logic [BCD_W-1:0] r = '0;
    int unsigned v = value;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Pulse a request, scramble Bcd after acceptance, and wait (bounded) for Done_Sig.
  task automatic applyStimulus(input logic [BCD_W-1:0] bcd, output int lat, output logic seen);
    @(negedge Clk);
    Bcd = bcd;
    Do_Translate = 1'b1;
    @(posedge Clk);
    #1;
    Do_Translate = 1'b0;
    Bcd = ~bcd;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge Clk);
      #1;
      lat++;
      if (Done_Sig) seen = 1'b1;
    end
    checkOutput("done_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    int lat;
    logic seen;
    logic [BIN_W-1:0] expBin;
    logic expErr;
    logic [BCD_W-1:0] bcd;
    int pulses;
    int lastDone;

    vecs[0] = '{28'h0000000, 24'h000000, 1'b0, 25};
    vecs[1] = '{28'h1234567, 24'h12D687, 1'b0, 25};
    vecs[2] = '{28'h0065535, 24'h00FFFF, 1'b0, 25};
    vecs[3] = '{28'h9999999, 24'h98967F, 1'b0, 25};
    vecs[4] = '{28'h000000A, 24'h000000, 1'b1, 1};
    vecs[5] = '{28'h0000042, 24'h00002A, 1'b0, 25};
    vecs[6] = '{28'h9F00000, 24'h000000, 1'b1, 1};
    vecs[7] = '{28'h1000000, 24'h0F4240, 1'b0, 25};
    vecs[8] = '{28'h0000001, 24'h000001, 1'b0, 25};

    #12;
    checkOutput("reset_bin", 32'(Bin), 32'd0);
    checkOutput("reset_done", 32'(Done_Sig), 32'd0);
    checkOutput("reset_busy", 32'(Busy), 32'd0);
    checkOutput("reset_err", 32'(Err), 32'd0);
    @(negedge Clk);
    Rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].bcd, lat, seen);
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      checkOutput($sformatf("vec%0d_bin", i), 32'(Bin), 32'(vecs[i].bin));
      checkOutput($sformatf("vec%0d_err", i), 32'(Err), 32'(vecs[i].err));
      checkOutput($sformatf("vec%0d_busy_done", i), 32'(Busy), 32'd1);
      @(posedge Clk);
      #1;
      checkOutput($sformatf("vec%0d_done_pulse", i), 32'(Done_Sig), 32'd0);
      checkOutput($sformatf("vec%0d_busy_after", i), 32'(Busy), 32'd0);
      if (vecs[i].err) begin
        repeat (3) @(posedge Clk);
        #1;
        checkOutput($sformatf("vec%0d_err_held", i), 32'(Err), 32'd1);
      end
    end

    // Re-request mid-conversion with a different operand must be ignored.
    @(negedge Clk);
    Bcd = 28'h1234567;
    Do_Translate = 1'b1;
    @(posedge Clk);
    #1;
    Do_Translate = 1'b0;
    pulses = 0;
    lastDone = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge Clk);
      #1;
      if (Done_Sig) begin
        pulses++;
        lastDone = c;
        checkOutput("repulse_bin", 32'(Bin), 32'h12D687);
      end
      if (c == 10) begin
        Do_Translate = 1'b1;
        Bcd = 28'h0000042;
      end else if (c == 11) begin
        Do_Translate = 1'b0;
      end
    end
    checkOutput("repulse_count", 32'(pulses), 32'd1);
    checkOutput("repulse_latency", 32'(lastDone), 32'd25);

    // Asynchronous reset part-way through the shift phase.
    applyStimulus(28'h9999999, lat, seen);
    checkOutput("prereset_bin", 32'(Bin), 32'h98967F);
    @(negedge Clk);
    Bcd = 28'h1234567;
    Do_Translate = 1'b1;
    @(posedge Clk);
    #1;
    Do_Translate = 1'b0;
    repeat (12) @(posedge Clk);
    #2;
    Rst = 1'b1;
    #1;
    checkOutput("midrst_bin", 32'(Bin), 32'd0);
    checkOutput("midrst_busy", 32'(Busy), 32'd0);
    checkOutput("midrst_done", 32'(Done_Sig), 32'd0);
    checkOutput("midrst_err", 32'(Err), 32'd0);
    @(negedge Clk);
    Rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge Clk);
      #1;
      if (Done_Sig) pulses++;
    end
    checkOutput("midrst_no_done", 32'(pulses), 32'd0);
    applyStimulus(28'h0001000, lat, seen);
    checkOutput("postrst_bin", 32'(Bin), 32'h0003E8);
    checkOutput("postrst_latency", 32'(lat), 32'd25);

    // Request held high: a new conversion starts each time IDLE is reached.
    @(negedge Clk);
    Bcd = 28'h0000255;
    Do_Translate = 1'b1;
    pulses = 0;
    lastDone = -1;
    for (int c = 0; c < 100; c++) begin
      @(posedge Clk);
      #1;
      if (Done_Sig) begin
        if (pulses == 0) checkOutput("held_first", 32'(c), 32'd25);
        else checkOutput("held_spacing", 32'(c - lastDone), 32'd26);
        checkOutput("held_bin", 32'(Bin), 32'h0000FF);
        pulses++;
        lastDone = c;
      end
    end
    Do_Translate = 1'b0;
    checkOutput("held_count", 32'(pulses), 32'd3);
    repeat (40) @(posedge Clk);
    #1;
    checkOutput("held_drain_busy", 32'(Busy), 32'd0);
    checkOutput("held_final_bin", 32'(Bin), 32'h0000FF);

    // Randomized sweep: even iterations are valid decimal, odd ones raw 28-bit patterns.
    for (int n = 0; n < 40; n++) begin
      if (n % 2 == 0) bcd = toBcd($urandom_range(0, 9999999));
      else bcd = BCD_W'($urandom);
      refModel(bcd, expBin, expErr);
      applyStimulus(bcd, lat, seen);
      checkOutput($sformatf("rand%0d_bin bcd=%0h", n, bcd), 32'(Bin), 32'(expBin));
      checkOutput($sformatf("rand%0d_err bcd=%0h", n, bcd), 32'(Err), 32'(expErr));
      checkOutput($sformatf("rand%0d_latency", n), 32'(lat), expErr ? 32'd1 : 32'd25);
      if (!expErr)
        checkOutput($sformatf("rand%0d_bcd_residue", n), 32'(dut.work_q[BCD_W+BIN_W-1:BIN_W]), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
